// File: rtl/eq_gain_loader.sv
// CPU-side loader for the equalizer gain RAM: shadows byte writes, snapshots on commit,
// and streams the snapshot into the equalizer on a frame boundary.
module eq_gain_loader #(
  parameter int unsigned num_of_filters = 4,
  parameter logic [15:0] gain_reset     = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_wr,
  input  logic [3:0]  cpu_addr,
  input  logic        cpu_byte_sel,
  input  logic [7:0]  cpu_data,
  input  logic [3:0]  cpu_rd_addr,
  output logic [15:0] cpu_rd_data,
  input  logic        commit,
  input  logic        sample_stb,
  output logic        busy,
  output logic        done,
  output logic        resync,
  input  logic        clear_flag,
  output logic        eq_wr,
  output logic [7:0]  eq_gain_lsb,
  output logic [7:0]  eq_gain_msb,
  input  logic        wr_addr_zero
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SNAP      = 3'd1;
  localparam logic [2:0] S_WAIT      = 3'd2;
  localparam logic [2:0] S_ALIGN_WR  = 3'd3;
  localparam logic [2:0] S_ALIGN_CHK = 3'd4;
  localparam logic [2:0] S_LOAD_WR   = 3'd5;
  localparam logic [2:0] S_LOAD_GAP  = 3'd6;

  localparam logic [4:0] NF       = 5'(num_of_filters);
  localparam logic [3:0] LAST_IDX = 4'(num_of_filters - 1);

  // Tables are sized for the full 4-bit index space; entries >= num_of_filters stay constant.
  logic [15:0] r_shadow [0:15];
  logic [15:0] r_snap   [0:15];
  logic [2:0]  r_state;
  logic [3:0]  r_idx;
  logic        r_pending;
  logic        r_eq_wr;
  logic        r_busy;
  logic        r_done;
  logic        r_resync;
  logic [7:0]  r_lsb;
  logic [7:0]  r_msb;
  logic        w_wr_ok;
  logic        w_rd_ok;

  assign w_wr_ok     = cpu_wr && ({1'b0, cpu_addr} < NF);
  assign w_rd_ok     = {1'b0, cpu_rd_addr} < NF;
  assign cpu_rd_data = w_rd_ok ? r_shadow[cpu_rd_addr] : '0;

  assign busy        = r_busy;
  assign done        = r_done;
  assign resync      = r_resync;
  assign eq_wr       = r_eq_wr;
  assign eq_gain_lsb = r_lsb;
  assign eq_gain_msb = r_msb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) r_shadow[i] <= gain_reset;
    end else if (w_wr_ok) begin
      if (cpu_byte_sel) r_shadow[cpu_addr][15:8] <= cpu_data;
      else              r_shadow[cpu_addr][7:0]  <= cpu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) r_snap[i] <= gain_reset;
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_eq_wr   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_resync  <= 1'b0;
      r_lsb     <= '0;
      r_msb     <= '0;
    end else begin
      r_eq_wr <= 1'b0;
      r_done  <= 1'b0;
      if (commit && (r_state != S_IDLE || r_done)) r_pending <= 1'b1;
      if (clear_flag) r_resync <= 1'b0;
      // Write strobes and data are registered on the transition into a *_WR state.
      case (r_state)
        S_IDLE: begin
          if (commit || r_pending) begin
            r_state <= S_SNAP;
            r_busy  <= 1'b1;
          end
        end
        S_SNAP: begin
          for (int unsigned i = 0; i < 16; i++) r_snap[i] <= r_shadow[i];
          r_pending <= commit;
          r_state   <= S_WAIT;
        end
        S_WAIT, S_ALIGN_CHK: begin
          if (r_state == S_ALIGN_CHK || sample_stb) begin
            r_eq_wr <= 1'b1;
            if (wr_addr_zero) begin
              r_state        <= S_LOAD_WR;
              r_idx          <= '0;
              {r_msb, r_lsb} <= r_snap[0];
            end else begin
              r_state <= S_ALIGN_WR;
              r_lsb   <= '0;
              r_msb   <= '0;
              if (r_state == S_WAIT) r_resync <= 1'b1;
            end
          end
        end
        S_ALIGN_WR: r_state <= S_ALIGN_CHK;
        S_LOAD_WR:  r_state <= S_LOAD_GAP;
        S_LOAD_GAP: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx          <= r_idx + 4'd1;
            r_state        <= S_LOAD_WR;
            r_eq_wr        <= 1'b1;
            {r_msb, r_lsb} <= r_snap[r_idx + 4'd1];
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/eq_gain_loader.md
Name: eq_gain_loader

Overview:
- CPU-side initiator for the equalizer gain RAM write port (eq_wr / eq_gain_lsb / eq_gain_msb / wr_addr_zero).
- Collects byte-wide CPU writes into a shadow gain table and snapshots the table on commit.
- Streams the snapshot into the equalizer in address order, starting on an audio frame boundary, so a whole table changes between two samples.
- Realigns the equalizer's auto-incrementing write address when it is not at zero.

Parameters:
- num_of_filters, 4: gain entries per table; must match the equalizer's num_of_filters (1..16).
- gain_reset, 16'h0000: reset value of every shadow and snapshot entry.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_wr  in  1  single-cycle byte write strobe.
- cpu_addr  in  4  gain index; values >= num_of_filters are ignored.
- cpu_byte_sel  in  1  0 = lsb byte, 1 = msb byte.
- cpu_data  in  8  write byte.
- cpu_rd_addr  in  4  shadow readback index.
- cpu_rd_data  out  16  shadow[cpu_rd_addr], combinational; 0 if index out of range.
- commit  in  1  strobe requesting a table load.
- sample_stb  in  1  frame-boundary strobe (r_data_en of the audio pipe).
- busy  out  1  high from commit acceptance through the last write gap.
- done  out  1  one-cycle pulse after a table load completes.
- resync  out  1  sticky; set when alignment writes were needed. Cleared by clear_flag.
- clear_flag  in  1  clears resync.
- eq_wr  out  1  write strobe to the equalizer.
- eq_gain_lsb  out  8  write data [7:0].
- eq_gain_msb  out  8  write data [15:8].
- wr_addr_zero  in  1  equalizer write address == 0.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-load):
  - eq_wr, busy, done, resync = 0; eq_gain_lsb/msb = 0.
  - shadow and snapshot = gain_reset; pending = 0; idx = 0; state = IDLE.
- Shadow writes: on cpu_wr with cpu_addr < num_of_filters, the selected byte of shadow[cpu_addr] updates at the clock edge. Accepted in every state.
- Commit acceptance:
  - In IDLE, commit moves the FSM to SNAP.
  - While busy, commit sets pending. Multiple commits collapse to one.
  - If commit and done occur in the same cycle, pending is set.
- FSM states:
  - IDLE: busy = 0. Goes to SNAP on commit or pending.
  - SNAP: 1 cycle; snapshot <= shadow; pending <= 0; busy = 1. A cpu_wr in the commit cycle is included in the snapshot; a cpu_wr during SNAP is not. Goes to WAIT_FRAME.
  - WAIT_FRAME: waits for sample_stb. On sample_stb: if wr_addr_zero, go to LOAD_WR with idx = 0; otherwise go to ALIGN_WR and set resync.
  - ALIGN_WR: eq_wr = 1, data = 16'h0000. Goes to ALIGN_CHK.
  - ALIGN_CHK: eq_wr = 0. If wr_addr_zero, go to LOAD_WR with idx = 0; otherwise go to ALIGN_WR.
  - LOAD_WR: eq_wr = 1, {msb, lsb} = snapshot[idx]. Goes to LOAD_GAP.
  - LOAD_GAP: eq_wr = 0. If idx == num_of_filters-1, go to IDLE and pulse done next cycle; otherwise idx++ and go to LOAD_WR.
- Write pacing: eq_wr is never high on two consecutive cycles. All outputs are registered.
- Timing:
  - First eq_wr is high in the cycle after sample_stb when aligned.
  - A load takes 2*num_of_filters cycles.
  - Alignment adds 2*(num_of_filters - k) cycles, where k is the equalizer's current write address.
- eq_gain_lsb/msb hold their last value whenever eq_wr = 0.
- Arithmetic: idx is 4 bits. sample_stb outside WAIT_FRAME is ignored.
- clear_flag and a resync set in the same cycle: set wins.

Test Plan:
- Basic load (N=4): write 0x1234, 0x2000, 0x4000, 0x7FFF via lsb/msb; commit; sample_stb -> eq_wr on cycles +1, +3, +5, +7 carrying those values in order; done at +9; resync = 0.
- Misaligned target: equalizer address preset to 2 (wr_addr_zero = 0); commit; sample_stb -> two writes of 0x0000, then four table writes; resync = 1; clear_flag -> resync = 0.
- Commit while busy: second commit mid-load, with shadow[0] changed to 0x1111 before it -> after done, a second load runs on the next sample_stb with entry 0 = 0x1111.
- Snapshot isolation: cpu_wr to shadow[3] during LOAD_WR of idx 1 -> the current load still writes the old shadow[3]; cpu_rd_data at index 3 shows the new value.
- Async reset asserted during LOAD_GAP -> eq_wr, busy, done = 0 immediately; cpu_rd_data = gain_reset at all indices; no eq_wr until a new commit.
- Out-of-range write: cpu_addr = 5 with N=4 -> no shadow entry changes; cpu_rd_addr = 5 -> 0.
